bmp_stream_tx: RTL and testbench
================================

BMP_STREAM_TX -- requirements
Module: bmp_stream_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 200, image width in pixels (1..4095).
REQ-002 SHALL have parameter HEIGHT, default 200, image height in rows (1..4095).
REQ-003 SHALL have port pixClk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port start, input, 1, frame-start request; sampled only in IDLE.
REQ-006 SHALL have port pix_in, input, 24, pixel {R[23:16],G[15:8],B[7:0]}.
REQ-007 SHALL have port pix_valid, input, 1, pix_in valid.
REQ-008 SHALL have port pix_ready, output, 1, block accepts pix_in this cycle.
REQ-009 SHALL have port byte_out, output, 8, BMP file byte.
REQ-010 SHALL have port byte_valid, output, 1, byte_out valid.
REQ-011 SHALL have port byte_ready, input, 1, downstream accepts byte_out.
REQ-012 SHALL have port busy, output, 1, high in any state except IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse at frame end.

Function
REQ-014 SHALL emit one complete 24-bpp BMP file per frame: 54-byte header, then HEIGHT rows of WIDTH pixels, each row followed by PAD zero bytes.
REQ-015 SHALL compute ROWB=3*WIDTH, PAD=(4-(ROWB mod 4)) mod 4, IMG=(ROWB+PAD)*HEIGHT, FSIZE=54+IMG as elaboration-time constants.
REQ-016 SHALL emit header bytes, multi-byte fields little-endian: 0:0x42, 1:0x4D, 2-5:FSIZE, 6-9:0, 10-13:54, 14-17:40, 18-21:WIDTH, 22-25:HEIGHT, 26-27:1, 28-29:24, 30-33:0, 34-37:IMG, 38-41:2835, 42-45:2835, 46-53:0.
REQ-017 SHALL implement FSM IDLE->HDR->PIX->PAD->PIX ...->DONE->IDLE; PAD skipped when PAD=0.
REQ-018 IDLE: byte_valid=0, pix_ready=0; start=1 at edge N moves to HDR with byte_valid=1, byte_out=0x42 after edge N.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 A byte transfers on any edge with byte_valid=1 and byte_ready=1; while byte_ready=0, byte_out and byte_valid SHALL hold.
REQ-021 Sustained throughput SHALL be one byte per cycle when byte_ready=1 and a pixel is available.
REQ-022 PIX: pix_ready=1 only when no pixel bytes are pending and the output register is empty or transferring this cycle; the pixel is accepted on pix_valid & pix_ready.
REQ-023 An accepted pixel SHALL be emitted as B, G, R (pix_in[7:0], [15:8], [23:16]) on consecutive transfers.
REQ-024 While waiting for a pixel, byte_valid SHALL be 0 (no bubbles filled).
REQ-025 Pixels SHALL be written in arrival order; bottom-up row ordering is the source's responsibility.
REQ-026 Column counter SHALL wrap 0..WIDTH-1; at wrap, PAD state emits PAD bytes of 0x00, then the row counter increments.
REQ-027 After the last pad byte (or last R byte when PAD=0) of row HEIGHT-1 transfers, the FSM SHALL enter DONE; done=1 for exactly that cycle, then IDLE.
REQ-028 pix_valid SHALL be ignored outside PIX; excess pixels remain unaccepted.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force IDLE, clear all counters, byte_valid=0, pix_ready=0, busy=0, done=0, byte_out=0.
REQ-030 Reset mid-frame SHALL abort the frame with no done pulse; the next start begins a fresh header.
REQ-031 rst_n SHALL take priority over start and every handshake in the same cycle.

Verification
REQ-032 WIDTH=2, HEIGHT=2, byte_ready=1, pixels 0x112233, 0x445566, 0x778899, 0xAABBCC -> 70 bytes; bytes 2-5 = 46 00 00 00, bytes 34-37 = 10 00 00 00, bytes 54-61 = 33 22 11 66 55 44 00 00; done pulses once.
REQ-033 WIDTH=4, HEIGHT=1 -> PAD=0, 66 bytes total, no zero bytes between pixel triples, FSIZE bytes = 42 00 00 00.
REQ-034 byte_ready toggled pseudo-randomly -> output byte sequence identical to REQ-032; byte_out is stable throughout every stall.
REQ-035 start pulsed again during PIX -> ignored; exactly one file emitted, busy stays 1 until done.
REQ-036 rst_n low for one cycle at header byte 20, then start -> no done; the next frame begins 0x42 0x4D, complete and correct.
REQ-037 pix_valid held low 10 cycles mid-row -> byte_valid=0 throughout; pixel stream resumes with no lost or duplicated bytes.

Source files
------------

// File: rtl/bmp_stream_tx.sv
// Streams one 24-bpp BMP file per frame: fixed 54-byte header, then the pixel rows
// (B,G,R per pixel) with zero padding to a 4-byte row boundary.
module bmp_stream_tx #(
    parameter int WIDTH  = 200,
    parameter int HEIGHT = 200
) (
    input  logic        pixClk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        busy,
    output logic        done
);

    localparam int ROWB  = 3 * WIDTH;
    localparam int PAD   = (4 - (ROWB % 4)) % 4;
    localparam int IMG   = (ROWB + PAD) * HEIGHT;
    localparam int FSIZE = 54 + IMG;

    localparam logic [11:0] COL_LAST = 12'(WIDTH - 1);
    localparam logic [11:0] ROW_LAST = 12'(HEIGHT - 1);
    localparam logic [1:0]  PAD_LAST = 2'(PAD);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_PIX  = 3'd2;
    localparam logic [2:0] S_PAD  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]  state;
    logic [5:0]  hdr_idx;   // index of the next header byte to load
    logic [11:0] col;
    logic [11:0] row;
    logic        row_end;   // last pixel of the row has been accepted
    logic [1:0]  pend;      // pixel bytes still to load after the current one
    logic [1:0]  pad_idx;   // pad bytes loaded so far in this row
    logic [15:0] hold;      // {R,G} of the pixel being emitted
    logic        xfer;

    // Every 4-byte field starts at an offset == 2 (mod 4), so the low index bits
    // select the little-endian byte directly.
    function automatic logic [7:0] hdr_byte(input logic [5:0] idx);
        logic [31:0] f;
        logic [1:0]  sh;
        sh = idx[1:0] - 2'd2;
        case (idx) inside
            [6'd2:6'd5]:   f = 32'(FSIZE);
            [6'd10:6'd13]: f = 32'd54;
            [6'd14:6'd17]: f = 32'd40;
            [6'd18:6'd21]: f = 32'(WIDTH);
            [6'd22:6'd25]: f = 32'(HEIGHT);
            [6'd26:6'd27]: f = 32'd1;
            [6'd34:6'd37]: f = 32'(IMG);
            [6'd38:6'd45]: f = 32'd2835;
            default:       f = 32'd0;
        endcase
        hdr_byte = 8'(f >> {sh, 3'b000});
        if (idx == 6'd0)  hdr_byte = 8'h42;
        if (idx == 6'd1)  hdr_byte = 8'h4D;
        if (idx == 6'd28) hdr_byte = 8'h18;
    endfunction

    assign xfer      = byte_valid && byte_ready;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign pix_ready = (state == S_PIX) && (pend == 2'd0) && !row_end &&
                       (!byte_valid || byte_ready);

    // NOTE: reset is synchronous, so it lives inside the clocked branch and wins over
    // every other condition; all state uses non-blocking assignments.
    always_ff @(posedge pixClk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            hdr_idx    <= 6'd0;
            col        <= 12'd0;
            row        <= 12'd0;
            row_end    <= 1'b0;
            pend       <= 2'd0;
            pad_idx    <= 2'd0;
            hold       <= 16'd0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state      <= S_HDR;
                    byte_out   <= 8'h42;
                    byte_valid <= 1'b1;
                    hdr_idx    <= 6'd1;
                    col        <= 12'd0;
                    row        <= 12'd0;
                    row_end    <= 1'b0;
                    pend       <= 2'd0;
                end
                S_HDR: if (xfer) begin
                    if (hdr_idx == 6'd54) begin
                        byte_valid <= 1'b0;
                        state      <= S_PIX;
                    end else begin
                        byte_out <= hdr_byte(hdr_idx);
                        hdr_idx  <= hdr_idx + 6'd1;
                    end
                end
                S_PIX: begin
                    if (pix_ready && pix_valid) begin
                        byte_out   <= pix_in[7:0];
                        byte_valid <= 1'b1;
                        hold       <= pix_in[23:8];
                        pend       <= 2'd2;
                        if (col == COL_LAST) begin
                            col     <= 12'd0;
                            row_end <= 1'b1;
                        end else begin
                            col <= col + 12'd1;
                        end
                    end else if (xfer) begin
                        if (pend != 2'd0) begin
                            byte_out <= (pend == 2'd2) ? hold[7:0] : hold[15:8];
                            pend     <= pend - 2'd1;
                        end else begin
                            byte_valid <= 1'b0;
                            if (row_end) begin
                                if (PAD != 0) begin
                                    state      <= S_PAD;
                                    byte_out   <= 8'h00;
                                    byte_valid <= 1'b1;
                                    pad_idx    <= 2'd1;
                                end else begin
                                    row_end <= 1'b0;
                                    if (row == ROW_LAST) state <= S_DONE;
                                    else row <= row + 12'd1;
                                end
                            end
                        end
                    end
                end
                S_PAD: if (xfer) begin
                    if (pad_idx == PAD_LAST) begin
                        byte_valid <= 1'b0;
                        row_end    <= 1'b0;
                        if (row == ROW_LAST) begin
                            state <= S_DONE;
                        end else begin
                            row   <= row + 12'd1;
                            state <= S_PIX;
                        end
                    end else begin
                        pad_idx <= pad_idx + 2'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bmp_stream_tx.sv
// Directed checks of bmp_stream_tx: a 2x2 image (padded rows) and a 4x1 image (no padding).
module tb_bmp_stream_tx;

    logic        pixClk = 1'b0;
    logic        rst_n, start, sel, pix_valid, byte_ready;
    logic [23:0] pix_in;
    logic        start_a, start_b;
    logic        pr_a, bv_a, busy_a, done_a, pr_b, bv_b, busy_b, done_b;
    logic [7:0]  bo_a, bo_b;
    logic        o_pr, o_bv, o_busy, o_done;
    logic [7:0]  o_bo;

    always #5 pixClk = ~pixClk;

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign o_pr    = sel ? pr_b   : pr_a;
    assign o_bv    = sel ? bv_b   : bv_a;
    assign o_bo    = sel ? bo_b   : bo_a;
    assign o_busy  = sel ? busy_b : busy_a;
    assign o_done  = sel ? done_b : done_a;

    bmp_stream_tx #(.WIDTH(2), .HEIGHT(2)) dut_a (
        .pixClk(pixClk), .rst_n(rst_n), .start(start_a), .pix_in(pix_in),
        .pix_valid(pix_valid), .pix_ready(pr_a), .byte_out(bo_a), .byte_valid(bv_a),
        .byte_ready(byte_ready), .busy(busy_a), .done(done_a));

    bmp_stream_tx #(.WIDTH(4), .HEIGHT(1)) dut_b (
        .pixClk(pixClk), .rst_n(rst_n), .start(start_b), .pix_in(pix_in),
        .pix_valid(pix_valid), .pix_ready(pr_b), .byte_out(bo_b), .byte_valid(bv_b),
        .byte_ready(byte_ready), .busy(busy_b), .done(done_b));

    int checks = 0;
    int errors = 0;

    logic [7:0]  rx [128];
    logic [7:0]  exp_a [70];
    logic [7:0]  exp_b [66];
    logic [23:0] tab_a [5] = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC, 24'hDEADBE};
    logic [23:0] tab_b [5] = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C, 24'hFFFFFF};
    logic [7:0]  hdr [54] = '{
        8'h42, 8'h4D, 8'h46, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h36, 8'h00, 8'h00, 8'h00, 8'h28, 8'h00, 8'h00, 8'h00,
        8'h02, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
        8'h01, 8'h00, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h10, 8'h00, 8'h00, 8'h00, 8'h13, 8'h0B, 8'h00, 8'h00,
        8'h13, 8'h0B, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0]  pix_a [16] = '{8'h33, 8'h22, 8'h11, 8'h66, 8'h55, 8'h44, 8'h00, 8'h00,
                                8'h99, 8'h88, 8'h77, 8'hCC, 8'hBB, 8'hAA, 8'h00, 8'h00};
    logic [7:0]  pix_b [12] = '{8'h03, 8'h02, 8'h01, 8'h06, 8'h05, 8'h04,
                                8'h09, 8'h08, 8'h07, 8'h0C, 8'h0B, 8'h0A};

    int n_bytes, n_done, acc, stall_bad, gap_bad;
    bit busy_drop, timeout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drives one frame on the selected DUT and records every transferred byte.
    task automatic run_frame(input bit stall, input int gap_after, input bit restart_mid);
        int  cycles, gap_left, gk, after_done;
        bit  seen_done, gap_done, pulsed, hold_prev, rdy, pv;
        logic [7:0] prev_bo;
        n_bytes = 0; n_done = 0; acc = 0; stall_bad = 0; gap_bad = 0;
        busy_drop = 0; timeout = 0;
        cycles = 0; gap_left = 0; after_done = 0;
        seen_done = 0; gap_done = 0; pulsed = 0; hold_prev = 0; prev_bo = 8'h00;
        @(negedge pixClk);
        start = 1'b1;
        forever begin
            @(negedge pixClk);
            start = 1'b0;
            gk = 0;
            pv = 1'b1;
            rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (gap_left > 0) begin
                gk = 11 - gap_left;
                gap_left--;
                pv = 1'b0;
                rdy = 1'b1;
            end
            if (restart_mid && acc == 2 && !pulsed) begin
                start = 1'b1;
                pulsed = 1;
            end
            byte_ready = rdy;
            pix_valid = pv;
            pix_in = sel ? tab_b[acc] : tab_a[acc];
            #1;
            if (hold_prev && (!o_bv || o_bo !== prev_bo)) stall_bad++;
            if (o_bv && rdy) begin
                if (n_bytes < 128) rx[n_bytes] = o_bo;
                n_bytes++;
            end
            hold_prev = o_bv && !rdy;
            prev_bo = o_bo;
            if (gk >= 4 && o_bv) gap_bad++;
            if (!seen_done && !o_busy) busy_drop = 1;
            if (o_pr && pv && acc < 4) begin
                acc++;
                if (gap_after > 0 && acc == gap_after && !gap_done) begin
                    gap_left = 10;
                    gap_done = 1;
                end
            end
            if (o_done) begin
                n_done++;
                seen_done = 1;
            end
            if (seen_done) after_done++;
            if (after_done > 3) break;
            cycles++;
            if (cycles > 3000) begin
                timeout = 1;
                break;
            end
        end
        start = 1'b0;
        pix_valid = 1'b0;
        byte_ready = 1'b1;
    endtask

    task automatic compare_frame(input string tag);
        int n;
        n = sel ? 66 : 70;
        check({tag, " timeout"}, 32'(timeout), 32'd0);
        check({tag, " byte count"}, 32'(n_bytes), 32'(n));
        check({tag, " done pulses"}, 32'(n_done), 32'd1);
        check({tag, " pixels accepted"}, 32'(acc), 32'd4);
        for (int i = 0; i < n; i++)
            check($sformatf("%s byte %0d", tag, i), 32'(rx[i]), sel ? 32'(exp_b[i]) : 32'(exp_a[i]));
    endtask

    initial begin
        for (int i = 0; i < 54; i++) begin
            exp_a[i] = hdr[i];
            exp_b[i] = hdr[i];
        end
        exp_b[2] = 8'h42; exp_b[18] = 8'h04; exp_b[22] = 8'h01; exp_b[34] = 8'h0C;
        for (int i = 0; i < 16; i++) exp_a[54 + i] = pix_a[i];
        for (int i = 0; i < 12; i++) exp_b[54 + i] = pix_b[i];

        // Reset with start asserted: reset must win.
        rst_n = 1'b0; start = 1'b1; sel = 1'b0; pix_valid = 1'b1; byte_ready = 1'b1;
        pix_in = 24'h0;
        repeat (2) @(negedge pixClk);
        check("reset byte_valid", 32'(bv_a), 32'd0);
        check("reset pix_ready", 32'(pr_a), 32'd0);
        check("reset busy", 32'(busy_a), 32'd0);
        check("reset done", 32'(done_a), 32'd0);
        check("reset byte_out", 32'(bo_a), 32'd0);
        check("reset busy b", 32'(busy_b), 32'd0);
        start = 1'b0; pix_valid = 1'b0;
        @(negedge pixClk);
        rst_n = 1'b1;
        repeat (3) @(negedge pixClk);
        check("idle byte_valid", 32'(bv_a), 32'd0);
        check("idle busy", 32'(busy_a), 32'd0);

        run_frame(1'b0, 0, 1'b0);
        compare_frame("plain");

        run_frame(1'b1, 0, 1'b0);
        compare_frame("stall");
        check("stall hold", 32'(stall_bad), 32'd0);

        run_frame(1'b0, 0, 1'b1);
        compare_frame("restart");
        check("restart busy held", 32'(busy_drop), 32'd0);

        run_frame(1'b0, 1, 1'b0);
        compare_frame("gap");
        check("gap byte_valid low", 32'(gap_bad), 32'd0);

        // Abort a frame while header byte 20 sits in the output register.
        begin
            int k, dn;
            bit reached;
            k = 0; dn = 0; reached = 0;
            @(negedge pixClk);
            start = 1'b1;
            for (int c = 0; c < 200; c++) begin
                @(negedge pixClk);
                start = 1'b0;
                #1;
                if (o_done) dn++;
                if (o_bv && k == 20) begin
                    reached = 1;
                    break;
                end
                if (o_bv) k++;
            end
            check("abort reached byte 20", 32'(reached), 32'd1);
            rst_n = 1'b0;
            @(negedge pixClk);
            rst_n = 1'b1;
            check("abort byte_valid", 32'(o_bv), 32'd0);
            check("abort busy", 32'(o_busy), 32'd0);
            check("abort byte_out", 32'(o_bo), 32'd0);
            for (int c = 0; c < 5; c++) begin
                @(negedge pixClk);
                if (o_done) dn++;
            end
            check("abort no done", 32'(dn), 32'd0);
        end
        run_frame(1'b0, 0, 1'b0);
        compare_frame("after abort");

        sel = 1'b1;
        run_frame(1'b0, 0, 1'b0);
        compare_frame("4x1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
